cla_pipe_arbiter: RTL

- Round-robin arbiter that shares one fixed-latency pipelined CLA adder (W bits, LAT stages, no backpressure) between NREQ requesters.
- Tags each issued operation with the requester id in a shadow pipeline and routes each result back to its owner.
- Flags any misalignment between the adder's output-valid and the tag pipe as a sticky error.
- Sits between traffic sources and the pipelined adder, in the core clock domain behind the MMCM and the reset synchroniser.

---
 rtl/cla_arb_pkg.sv | 23 ++
 rtl/cla_rr_arbiter.sv | 34 +++
 rtl/cla_pipe_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cla_arb_pkg.sv
// Shared definitions for the pipelined-adder arbiter.
//   W_DEF / NREQ_DEF / LAT_DEF : default width, requester count, adder latency
//   tag_t                      : shadow-pipe entry {valid, id}; id sized for 16 requesters
//   onehot(id)                 : id -> one-hot, NREQ_MAX bits wide
package cla_arb_pkg;
  localparam int W_DEF    = 128;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 4;
  localparam int NREQ_MAX = 16;
  localparam int TAG_IDW  = 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [TAG_IDW-1:0] id);
    logic [NREQ_MAX-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/cla_rr_arbiter.sv
// Combinational round-robin pick.
//   req    : per-requester valid
//   en     : grant enable
//   ptr    : last granted id; search starts at ptr+1 and wraps
//   gnt    : one-hot grant (zero when en low or no request)
//   gnt_id : encoded id of gnt
module cla_rr_arbiter import cla_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    // k runs 1..NREQ so the last-granted requester is visited last
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/cla_pipe_arbiter.sv
// Shares one fixed-latency pipelined adder between NREQ requesters.
// Grants round-robin, registers the winning operands toward the adder,
// carries the owner id alongside the adder in a LAT-deep tag pipe and
// routes each sum back one cycle after add_vout. Any disagreement between
// add_vout and the tag pipe tail sets a sticky error.
//   clk, rstn                  : clock, async active-low reset
//   en                         : grant enable
//   req_valid/ready/a/b/cin    : requester side, packed per requester
//   add_valid/a/b/cin          : issue to adder
//   add_vout/sum/cout          : adder result
//   rsp_valid/id/sum/cout      : one-hot routed result, single cycle
//   busy, error                : in-flight indication, sticky mismatch
module cla_pipe_arbiter import cla_arb_pkg::*; #(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              add_valid,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_cin,
  input  logic              add_vout,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic              error
);
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            hs;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            add_valid_q, add_valid_d;
  logic [W-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
  logic            add_cin_q, add_cin_d;
  logic [IDW-1:0]  iss_id_q, iss_id_d;
  tag_t            tag_q [LAT];
  tag_t            tag_in, tail;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            error_q, error_d;
  logic            mismatch, route, inflight;

  // rstn gates the enable so no grant is shown while reset is held
  cla_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req    (req_valid),
    .en     (en & rstn),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  // issue stage: operands held when nothing is granted
  always_comb begin
    ptr_d       = hs ? gnt_id : ptr_q;
    add_valid_d = hs;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    iss_id_d    = hs ? gnt_id : iss_id_q;
    if (hs) begin
      add_a_d   = '0;
      add_b_d   = '0;
      add_cin_d = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          add_a_d   = add_a_d | req_a[i*W +: W];
          add_b_d   = add_b_d | req_b[i*W +: W];
          add_cin_d = add_cin_d | req_cin[i];
        end
      end
    end
  end

  // the issue register acts as tag stage "-1", so tag_q[LAT-1]
  // lines up with add_vout at handshake + 1 + LAT
  assign tag_in   = '{valid: add_valid_q, id: TAG_IDW'(iss_id_q)};
  assign tail     = tag_q[LAT-1];
  assign mismatch = add_vout ^ tail.valid;
  assign route    = add_vout & tail.valid;

  always_comb begin
    rsp_valid_d = route ? NREQ'(onehot(tail.id)) : '0;
    rsp_id_d    = route ? IDW'(tail.id) : rsp_id_q;
    rsp_sum_d   = route ? add_sum : rsp_sum_q;
    rsp_cout_d  = route ? add_cout : rsp_cout_q;
    error_d     = error_q | mismatch;
  end

  always_comb begin
    inflight = add_valid_q | (|rsp_valid_q);
    for (int k = 0; k < LAT; k++) inflight = inflight | tag_q[k].valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= IDW'(NREQ - 1);
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      iss_id_q    <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      iss_id_q    <= iss_id_d;
      tag_q[0]    <= tag_in;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      error_q     <= error_d;
    end
  end

  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = inflight;
  assign error     = error_q;
endmodule
